// File: rtl/row_enc_pkg.sv
// Shared definitions for the round-robin row encoder.
package row_enc_pkg;
  localparam int unsigned N_ROWS_DEF = 8;
  localparam int unsigned AW_DEF     = 3;

  typedef enum logic {IDLE, GRANT} row_enc_state_t;
  typedef logic [AW_DEF-1:0] row_addr_t;
endpackage

// File: rtl/row_encoder_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr.
module rr_pick #(
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned AW     = $clog2(N_ROWS)
) (
  input  logic [N_ROWS-1:0] req,
  input  logic [AW-1:0]     ptr,
  output logic [AW-1:0]     idx,
  output logic              found,
  output logic              many
);
  logic [2*N_ROWS-1:0] dbl;
  logic [N_ROWS-1:0]   rot;
  logic [AW-1:0]       low;

  // Shifting the doubled vector gives a rotate-right by ptr.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_ROWS-1:0];

  always_comb begin
    low   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_ROWS; i++) begin
      if (rot[i] && !found) begin
        low   = AW'(i);
        found = 1'b1;
      end
    end
    many = |(rot & (rot - N_ROWS'(1)));
    // N_ROWS is a power of two, so AW-bit overflow is the modulo.
    idx  = low + ptr;
  end
endmodule

// File: rtl/row_encoder.sv
// Registered round-robin 8-to-3 row encoder with sticky valid/ack grants.
module row_encoder
  import row_enc_pkg::*;
#(
  parameter int unsigned N_ROWS = N_ROWS_DEF,
  parameter int unsigned AW     = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_b,
  input  logic [N_ROWS-1:0] row_req,
  input  logic              ack,
  output logic [AW-1:0]     addr,
  output logic              valid,
  output logic [N_ROWS-1:0] grant,
  output logic              multi
);
  row_enc_state_t    state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [N_ROWS-1:0] grant_q, grant_d;
  logic              multi_q, multi_d;

  logic              accept;
  logic [N_ROWS-1:0] pick_req;
  logic [AW-1:0]     pick_ptr;
  logic [AW-1:0]     pick_idx;
  logic              pick_found;
  logic              pick_many;

  assign accept = (state_q == GRANT) && ack;

  // On an accepted grant, re-arbitrate with the advanced pointer and the granted row masked.
  always_comb begin
    pick_req = row_req;
    pick_ptr = ptr_q;
    if (accept) begin
      pick_req = row_req & ~grant_q;
      pick_ptr = addr_q + AW'(1);
    end
  end

  rr_pick #(
    .N_ROWS (N_ROWS),
    .AW     (AW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found),
    .many  (pick_many)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    multi_d = multi_q;
    if (state_q == IDLE || accept) begin
      if (accept) begin
        ptr_d = pick_ptr;
      end
      if (!en_b && pick_found) begin
        state_d = GRANT;
        addr_d  = pick_idx;
        grant_d = N_ROWS'(1) << pick_idx;
        multi_d = pick_many;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
    end
  end

  assign addr  = addr_q;
  assign valid = (state_q == GRANT);
  assign grant = grant_q;
  assign multi = multi_q;
endmodule

// File: tb/tb_row_encoder.sv
// Directed and randomized checks of row_encoder against a behavioural arbiter model.
module tb_row_encoder;
  logic       clk;
  logic       rst_n;
  logic       en_b;
  logic [7:0] row_req;
  logic       ack;
  logic [2:0] addr;
  logic       valid;
  logic [7:0] grant;
  logic       multi;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference model state
  bit          m_valid;
  int unsigned m_addr;
  int unsigned m_ptr;
  bit          m_multi;

  row_encoder #(
    .N_ROWS (8),
    .AW     (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_b    (en_b),
    .row_req (row_req),
    .ack     (ack),
    .addr    (addr),
    .valid   (valid),
    .grant   (grant),
    .multi   (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned c = 0;
    for (int unsigned i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int unsigned first_from(input logic [7:0] v, input int unsigned p);
    for (int unsigned k = 0; k < 8; k++) begin
      int unsigned i = (p + k) % 8;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_addr  = 0;
    m_ptr   = 0;
    m_multi = 0;
  endtask

  task automatic model_step();
    logic [7:0] elig;
    if (!m_valid) begin
      elig = row_req;
      if (!en_b && elig != 8'h00) begin
        m_valid = 1;
        m_addr  = first_from(elig, m_ptr);
        m_multi = popcount(elig) > 1;
      end
    end else if (ack) begin
      m_ptr = (m_addr + 1) % 8;
      elig  = row_req;
      elig[m_addr] = 1'b0;
      if (!en_b && elig != 8'h00) begin
        m_addr  = first_from(elig, m_ptr);
        m_multi = popcount(elig) > 1;
      end else begin
        m_valid = 0;
        m_multi = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] exp_grant;
    exp_grant = m_valid ? (8'h01 << m_addr) : 8'h00;
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check({tag, ".multi"}, 32'(multi), 32'(m_multi));
    check({tag, ".addr"},  32'(addr),  32'(m_addr));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    en_b    = 1'b0;
    row_req = 8'h00;
    ack     = 1'b0;
    rst_n   = 1'b1;
    #2;
    do_reset();

    // Single request, sticky without ack
    row_req = 8'b0010_0000;
    tick("single");
    check("single.addr5", 32'(addr), 32'd5);
    check("single.grant20", 32'(grant), 32'h20);
    row_req = 8'h00;
    tick("single.hold");
    tick("single.hold2");
    check("single.hold_addr", 32'(addr), 32'd5);

    // Rotation from a fresh pointer
    do_reset();
    row_req = 8'hFF;
    tick("rot.first");
    check("rot.addr0", 32'(addr), 32'd0);
    ack = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      tick("rot");
      check("rot.seq", 32'(addr), (i + 1) % 8);
      check("rot.valid", 32'(valid), 32'd1);
      check("rot.multi", 32'(multi), 32'd1);
    end
    ack = 1'b0;

    // Wrap and skip
    do_reset();
    row_req = 8'h40;
    tick("wrap.g6");
    ack = 1'b1; row_req = 8'h00;
    tick("wrap.ack6");
    ack = 1'b0; row_req = 8'b0000_0101;
    tick("wrap.g0");
    check("wrap.addr0", 32'(addr), 32'd0);
    ack = 1'b1;
    tick("wrap.g2");
    check("wrap.addr2", 32'(addr), 32'd2);
    row_req = 8'h00;
    tick("wrap.idle");
    ack = 1'b0; row_req = 8'h20;
    tick("wrap.g5");
    ack = 1'b1; row_req = 8'b1000_0010;
    tick("wrap.g7");
    check("wrap.addr7", 32'(addr), 32'd7);
    ack = 1'b0; row_req = 8'h00;
    tick("wrap.hold7");

    // Enable gating
    do_reset();
    en_b = 1'b1; row_req = 8'h10;
    tick("en.blocked");
    check("en.blocked_valid", 32'(valid), 32'd0);
    en_b = 1'b0; row_req = 8'h08;
    tick("en.g3");
    en_b = 1'b1; row_req = 8'h00;
    tick("en.hold");
    tick("en.hold2");
    check("en.hold_addr3", 32'(addr), 32'd3);
    ack = 1'b1; row_req = 8'hFF;
    tick("en.release");
    check("en.release_valid", 32'(valid), 32'd0);
    ack = 1'b0; en_b = 1'b0;

    // Async reset mid-grant
    do_reset();
    row_req = 8'h10;
    tick("arst.g4");
    check("arst.addr4", 32'(addr), 32'd4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("arst.immediate");
    #3;
    rst_n = 1'b1;
    row_req = 8'hFF;
    tick("arst.after");
    check("arst.after_addr0", 32'(addr), 32'd0);

    // Randomized traffic
    for (int unsigned c = 0; c < 400; c++) begin
      row_req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) row_req = 8'h00;
      ack  = 1'($urandom);
      en_b = ($urandom_range(0, 5) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
